// File: rtl/calc_entry_seq.sv
`default_nettype none
// ============================================================================
// calc_entry_seq : enter/clear sequencer driving the calculator register bank
//                  and ALU handshake; define CALC_TIMEOUT_EN for the ALU timeout.
// Revision 1.0
// ============================================================================
module calc_entry_seq #(
    parameter int WIDTH   = 4,
    parameter int OPW     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             btn_enter_i,
    input  logic             btn_clear_i,
    input  logic [WIDTH-1:0] sw_i,
    input  logic             alu_done_i,
    output logic             ld_a_o,
    output logic             ld_b_o,
    output logic             ld_op_o,
    output logic             ld_r_o,
    output logic [WIDTH-1:0] ld_data_o,
    output logic             alu_start_o,
    output logic [2:0]       state_o,
    output logic             err_o
);

    localparam logic [2:0] S_GET_A  = 3'd0;
    localparam logic [2:0] S_GET_B  = 3'd1;
    localparam logic [2:0] S_GET_OP = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_STORE  = 3'd4;
    localparam logic [2:0] S_SHOW   = 3'd5;

    // bit0/bit1 synchronize, bit2 remembers the previous synchronized level
    logic [2:0]       ent_sync_q, clr_sync_q;
    logic             ent_pulse_w, clr_pulse_w;
    logic [2:0]       state_q, state_d;
    logic             ld_a_q, ld_a_d, ld_b_q, ld_b_d;
    logic             ld_op_q, ld_op_d, ld_r_q, ld_r_d;
    logic [WIDTH-1:0] ld_data_q, ld_data_d;
    logic             alu_start_q, alu_start_d;
    logic             timeout_w;

    assign ent_pulse_w = ent_sync_q[1] & ~ent_sync_q[2];
    assign clr_pulse_w = clr_sync_q[1] & ~clr_sync_q[2];

`ifdef CALC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // counter is zero on the first RUN cycle, so TIMEOUT-1 marks the last one
    assign timeout_w = (state_q == S_RUN) && (cnt_q == CW'(TIMEOUT - 1));
    assign cnt_d     = (state_q == S_RUN) ? cnt_q + CW'(1) : '0;

    always_comb begin
        err_d = err_q;
        if (clr_pulse_w) begin
            err_d = 1'b0;
        end else if (timeout_w && !alu_done_i) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_w = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            ent_sync_q  <= '0;
            clr_sync_q  <= '0;
            state_q     <= S_GET_A;
            ld_a_q      <= 1'b0;
            ld_b_q      <= 1'b0;
            ld_op_q     <= 1'b0;
            ld_r_q      <= 1'b0;
            ld_data_q   <= '0;
            alu_start_q <= 1'b0;
        end else begin
            ent_sync_q  <= {ent_sync_q[1:0], btn_enter_i};
            clr_sync_q  <= {clr_sync_q[1:0], btn_clear_i};
            state_q     <= state_d;
            ld_a_q      <= ld_a_d;
            ld_b_q      <= ld_b_d;
            ld_op_q     <= ld_op_d;
            ld_r_q      <= ld_r_d;
            ld_data_q   <= ld_data_d;
            alu_start_q <= alu_start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_pulse_w) begin
            state_d = S_GET_A;
        end else begin
            case (state_q)
                S_GET_A:  if (ent_pulse_w) state_d = S_GET_B;
                S_GET_B:  if (ent_pulse_w) state_d = S_GET_OP;
                S_GET_OP: if (ent_pulse_w) state_d = S_RUN;
                S_RUN: begin
                    if (alu_done_i) begin
                        state_d = S_STORE;
                    end else if (timeout_w) begin
                        state_d = S_SHOW;
                    end
                end
                S_STORE:  state_d = S_SHOW;
                S_SHOW:   if (ent_pulse_w) state_d = S_GET_B;
                default:  state_d = S_GET_A;
            endcase
        end
    end

    always_comb begin
        ld_a_d      = 1'b0;
        ld_b_d      = 1'b0;
        ld_op_d     = 1'b0;
        ld_r_d      = 1'b0;
        ld_data_d   = ld_data_q;
        alu_start_d = (state_d == S_RUN);
        if (!clr_pulse_w) begin
            case (state_q)
                S_GET_A, S_SHOW: begin
                    ld_a_d    = ent_pulse_w;
                    ld_data_d = ent_pulse_w ? sw_i : ld_data_q;
                end
                S_GET_B: begin
                    ld_b_d    = ent_pulse_w;
                    ld_data_d = ent_pulse_w ? sw_i : ld_data_q;
                end
                S_GET_OP: begin
                    ld_op_d   = ent_pulse_w;
                    ld_data_d = ent_pulse_w ? WIDTH'(sw_i[OPW-1:0]) : ld_data_q;
                end
                S_RUN:   ld_r_d = alu_done_i;
                default: ;
            endcase
        end
    end

    assign ld_a_o      = ld_a_q;
    assign ld_b_o      = ld_b_q;
    assign ld_op_o     = ld_op_q;
    assign ld_r_o      = ld_r_q;
    assign ld_data_o   = ld_data_q;
    assign alu_start_o = alu_start_q;
    assign state_o     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_entry_seq.sv
`default_nettype none
// tb_calc_entry_seq : scoreboard bench; expected strobes come from a timeline
// model of the calculator entry sequence, a monitor pops and compares them.
module tb_calc_entry_seq;
    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 15;
`ifdef CALC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             btn_enter = 1'b0;
    logic             btn_clear = 1'b0;
    logic             alu_done = 1'b0;
    logic [WIDTH-1:0] sw = '0;
    logic             ld_a, ld_b, ld_op, ld_r, alu_start, err;
    logic [WIDTH-1:0] ld_data;
    logic [2:0]       state;

    calc_entry_seq #(.WIDTH(WIDTH), .OPW(2), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .reset_i(reset_n), .btn_enter_i(btn_enter), .btn_clear_i(btn_clear),
        .sw_i(sw), .alu_done_i(alu_done), .ld_a_o(ld_a), .ld_b_o(ld_b), .ld_op_o(ld_op),
        .ld_r_o(ld_r), .ld_data_o(ld_data), .alu_start_o(alu_start), .state_o(state),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               kind;   // 0 ld_a, 1 ld_b, 2 ld_op, 3 ld_r
        logic [WIDTH-1:0] data;
        int               at;
    } exp_t;
    exp_t exp_q[$];
    int   len_q[$];

    // model: phase code, or 6 = inside an operation whose timeline is known
    int               m_phase    = 0;
    int               m_rs       = 0;
    int               m_len      = 0;
    bit               m_to       = 1'b0;
    int               m_err_from = -1;
    logic [WIDTH-1:0] m_data     = '0;
    int               alu_lat    = 0;

    function automatic int ph_at(int t);
        if (m_phase != 6) return m_phase;
        if (t < m_rs + m_len) return 3;
        if (!m_to && t == m_rs + m_len) return 4;
        return 5;
    endfunction

    function automatic int err_at(int t);
        return (m_err_from >= 0 && t >= m_err_from) ? 1 : 0;
    endfunction

    task automatic check(string name, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(int kind, logic [WIDTH-1:0] d, int at);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.at   = at;
        exp_q.push_back(e);
        if (kind != 3) m_data = d;
    endtask

    task automatic check_state(string name);
        int t;
        t = cyc;
        check({name, ".state"}, int'(state), ph_at(t));
        check({name, ".err"}, int'(err), err_at(t));
        check({name, ".alu_start"}, int'(alu_start), (ph_at(t) == 3) ? 1 : 0);
        check({name, ".ld_data"}, int'(ld_data), int'(m_data));
    endtask

    task automatic press(bit ent, bit clr, logic [WIDTH-1:0] v, int hold, int lat);
        int c;
        int ph;
        @(negedge clk);
        c         = cyc;
        sw        = v;
        btn_enter = ent;
        btn_clear = clr;
        ph        = ph_at(c + 2);
        if (clr) begin
            m_phase    = 0;
            m_err_from = -1;
        end else if (ent) begin
            case (ph)
                0, 5: begin push(0, v, c + 3); m_phase = 1; end
                1:    begin push(1, v, c + 3); m_phase = 2; end
                2: begin
                    push(2, {2'b00, v[1:0]}, c + 3);
                    alu_lat = lat;
                    m_phase = 6;
                    m_rs    = c + 3;
                    m_to    = 1'b0;
                    if (lat > 0 && (!TO_EN || lat <= TIMEOUT)) begin
                        m_len = lat;
                        push(3, '0, c + 3 + lat);
                        len_q.push_back(lat);
                    end else if (TO_EN) begin
                        m_len = TIMEOUT;
                        m_to  = 1'b1;
                        if (m_err_from < 0) m_err_from = c + 3 + TIMEOUT;
                        len_q.push_back(TIMEOUT);
                    end else begin
                        m_len = 1 << 30;
                    end
                end
                default: ;
            endcase
        end
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        reset_n    = 1'b0;
        btn_enter  = 1'b0;
        btn_clear  = 1'b0;
        alu_lat    = 0;
        exp_q.delete();
        len_q.delete();
        m_phase    = 0;
        m_err_from = -1;
        m_to       = 1'b0;
        m_data     = '0;
        repeat (n) @(negedge clk);
        check("reset.state", int'(state), 0);
        check("reset.strobes", int'({ld_a, ld_b, ld_op, ld_r}), 0);
        check("reset.alu_start", int'(alu_start), 0);
        check("reset.err", int'(err), 0);
        check("reset.ld_data", int'(ld_data), 0);
        reset_n = 1'b1;
    endtask

    // ALU model: raise done once alu_start has been seen for alu_lat cycles
    int alu_cnt = 0;
    always @(negedge clk) begin
        if (alu_start) begin
            alu_cnt++;
            if (alu_lat > 0 && alu_cnt >= alu_lat) alu_done = 1'b1;
        end else begin
            alu_cnt  = 0;
            alu_done = 1'b0;
        end
    end

    // monitor: every strobe pops one expectation; alu_start length is scored on its fall
    int run_cnt = 0;
    always @(negedge clk) begin
        logic [3:0] sb;
        exp_t       e;
        sb = {ld_r, ld_op, ld_b, ld_a};
        if (sb != 4'b0000) check("strobe_onehot", $countones(sb), 1);
        for (int k = 0; k < 4; k++) begin
            if (sb[k]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", k, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", k, e.kind);
                    check("strobe_cycle", cyc, e.at);
                    if (k != 3) check("strobe_data", int'(ld_data), int'(e.data));
                end
            end
        end
        if (alu_start) begin
            run_cnt++;
        end else begin
            if (run_cnt > 0 && len_q.size() > 0) check("alu_start_len", run_cnt, len_q.pop_front());
            run_cnt = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        do_reset(2);

        // full operation; opcode upper switch bits are masked off
        press(1, 0, 4'b1010, 1, 0);
        press(1, 0, 4'b0011, 2, 0);
        press(1, 0, 4'b1101, 1, 5);
        repeat (10) @(negedge clk);
        check_state("full_op");

        press(1, 0, 4'b0111, 1, 0);
        check_state("show_reentry");

        press(1, 1, 4'b1111, 1, 0);
        check_state("clear_wins");

        press(1, 0, 4'b0101, 20, 0);
        check_state("long_hold");

        press(1, 0, 4'b1001, 1, 0);
        press(1, 0, 4'b0010, 1, 12);
        press(1, 0, 4'b1000, 1, 0);
        check_state("enter_in_run");
        repeat (12) @(negedge clk);
        check_state("after_run");

        for (int i = 0; i < 6; i++) begin
            int lat;
            lat = $urandom_range(1, TIMEOUT);
            press(1, 0, WIDTH'($urandom), $urandom_range(1, 4), 0);
            press(1, 0, WIDTH'($urandom), $urandom_range(1, 4), 0);
            press(1, 0, WIDTH'($urandom), $urandom_range(1, 4), lat);
            repeat (lat + 4) @(negedge clk);
            check_state("random_op");
        end

        press(1, 0, 4'b0110, 1, 0);
        press(1, 0, 4'b1100, 1, 0);
        press(1, 0, 4'b0011, 1, 0);
`ifdef CALC_TIMEOUT_EN
        repeat (TIMEOUT + 2) @(negedge clk);
        check_state("timeout");
        press(1, 0, 4'b0001, 1, 0);
        check_state("err_sticky");
        press(0, 1, 4'b0000, 1, 0);
        check_state("timeout_clear");
`else
        repeat (100) @(negedge clk);
        check_state("no_timeout");
        press(0, 1, 4'b0000, 1, 0);
        check_state("run_clear");
`endif

        press(1, 0, 4'b1110, 1, 0);
        press(1, 0, 4'b0100, 1, 0);
        press(1, 0, 4'b0010, 1, 0);
        repeat (5) @(negedge clk);
        do_reset(2);
        repeat (3) @(negedge clk);
        check_state("after_mid_reset");

        press(1, 0, 4'b0001, 1, 0);
        press(1, 0, 4'b0010, 1, 0);
        press(1, 0, 4'b0011, 1, 3);
        repeat (10) @(negedge clk);
        check_state("recovery_op");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
